irq_vector_responder: RTL

- Interrupt-acknowledge responder for the CPU microcode sequencer: the far end of the intr/inta handshake.
- Latches up to 8 edge-triggered request lines, prioritises them, and raises intr.
- On the CPU's inta pulse it commits the winning level to in-service and presents an 8-bit vector, held stable, for the sequencer to capture into MDR.
- Small register port supplies vector base, mask, and end-of-interrupt (EOI) commands.

---
 rtl/irq_vector_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/irq_vector_responder.sv
// Interrupt-acknowledge responder: far end of the CPU intr/inta handshake.
//
// Latches rising edges on up to eight request lines into IRR, prioritises the
// unmasked pending levels (level 0 highest, fully nested against ISR) and
// raises a registered intr. On an inta pulse the winning level moves from IRR
// to ISR and an 8-bit vector {base, level} is presented until the next inta.
// With nothing pending at inta, the spurious vector {base, 7} is returned.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   irq        request lines, rising-edge sensitive, synchronous to clk
//   intr       registered interrupt request to the CPU
//   inta       single-cycle acknowledge pulse from the CPU
//   vector     vector number, valid from the cycle after inta
//   cfg_wr     register write strobe
//   cfg_rd     register read strobe
//   cfg_addr   register select: 0 base/IRR, 1 mask, 2 EOI/ISR, 3 base
//   cfg_wdata  register write data
//   cfg_rdata  registered read data
//   cfg_ack    one-cycle pulse the cycle after cfg_wr or cfg_rd
module irq_vector_responder #(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [7:0]  RESET_BASE = 8'h08
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               intr,
  input  logic               inta,
  output logic [7:0]         vector,
  input  logic               cfg_wr,
  input  logic               cfg_rd,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  output logic [7:0]         cfg_rdata,
  output logic               cfg_ack
);

  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [7:0]         irr_q, irr_d;
  logic [7:0]         isr_q, isr_d;
  logic [7:0]         mask_q, mask_d;
  logic [4:0]         base_q, base_d;
  logic               intr_q, intr_d;
  logic [7:0]         vector_q, vector_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               ack_q;

  logic [7:0] rise;
  logic [7:0] pend;
  logic [3:0] best;
  logic [3:0] isr_top;
  logic [7:0] isr_eoi;
  logic [7:0] irr_clr;
  logic       ack_hit;

  // Index of the lowest set bit, or 8 when the vector is empty.
  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    rise    = 8'(irq & ~irq_prev_q);
    pend    = irr_q & ~mask_q;
    best    = lowest_set(pend);
    isr_top = lowest_set(isr_q);

    // EOI is applied before an acknowledge arriving in the same cycle.
    isr_eoi = isr_q;
    if (cfg_wr && (cfg_addr == 2'd2)) begin
      if (cfg_wdata[3]) begin
        isr_eoi[cfg_wdata[2:0]] = 1'b0;
      end else if (!isr_top[3]) begin
        isr_eoi[isr_top[2:0]] = 1'b0;
      end
    end

    ack_hit = inta && (pend != 8'h00);
    isr_d   = isr_eoi;
    irr_clr = 8'h00;
    if (ack_hit) begin
      isr_d[best[2:0]]   = 1'b1;
      irr_clr[best[2:0]] = 1'b1;
    end
    // A new edge on the acknowledged line wins over the clear.
    irr_d = (irr_q & ~irr_clr) | rise;

    vector_d = vector_q;
    if (inta) begin
      vector_d = {base_q, ack_hit ? best[2:0] : 3'd7};
    end

    // Forced low right after inta so the CPU never sees a stale request.
    intr_d = !inta && (pend != 8'h00) && (best < isr_top);

    mask_d = mask_q;
    base_d = base_q;
    if (cfg_wr) begin
      unique case (cfg_addr)
        2'd0:    base_d = cfg_wdata[7:3];
        2'd1:    mask_d = cfg_wdata;
        default: ;
      endcase
    end

    // Reads observe pre-write state when a write lands in the same cycle.
    rdata_d = rdata_q;
    if (cfg_rd) begin
      unique case (cfg_addr)
        2'd0:    rdata_d = irr_q;
        2'd1:    rdata_d = mask_q;
        2'd2:    rdata_d = isr_q;
        default: rdata_d = {base_q, 3'b000};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_prev_q <= '0;
      irr_q      <= 8'h00;
      isr_q      <= 8'h00;
      mask_q     <= 8'hFF;
      base_q     <= RESET_BASE[7:3];
      intr_q     <= 1'b0;
      vector_q   <= 8'h00;
      rdata_q    <= 8'h00;
      ack_q      <= 1'b0;
    end else begin
      irq_prev_q <= irq;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      mask_q     <= mask_d;
      base_q     <= base_d;
      intr_q     <= intr_d;
      vector_q   <= vector_d;
      rdata_q    <= rdata_d;
      ack_q      <= cfg_wr | cfg_rd;
    end
  end

  assign intr      = intr_q;
  assign vector    = vector_q;
  assign cfg_rdata = rdata_q;
  assign cfg_ack   = ack_q;

endmodule
